// File: rtl/reg_file.sv
// reg_file: 32-entry architectural register file with one write port and two
// combinational read ports. Register 0 always reads zero. After reset a scrub
// sequencer clears entries 1..31 before the file reports ready and accepts writes.
module reg_file #(
  parameter int width = 32,
  parameter int depth = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [4:0]       waddr,
  input  logic [width-1:0] wdata,
  input  logic [4:0]       raddr1,
  input  logic [4:0]       raddr2,
  output logic [width-1:0] rdata1,
  output logic [width-1:0] rdata2,
  output logic             ready
);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             ready_q;
  logic [width-1:0] mem_q [depth];

  // Single storage write port, shared by the scrub sequencer and writeback
  logic             mem_we;
  logic [4:0]       mem_waddr;
  logic [width-1:0] mem_wdata;

  // Next-state logic: scrub walks cnt 1..31 in INIT; writeback owns the port in RUN
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if (rst) begin
      // Reset wins over any pending write; nothing is stored on this edge
      state_d = INIT;
      cnt_d   = 5'd1;
    end else if (state_q == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
      cnt_d     = cnt_q + 5'd1;
      // Leaving INIT at 31 means the counter wrap to 0 is never observed
      if (cnt_q == 5'd31) begin
        state_d = RUN;
      end
    end else if (we && (waddr != 5'd0)) begin
      mem_we = 1'b1;
    end
  end

  // FSM state, scrub counter and registered ready flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= 5'd1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == RUN);
    end
  end

  // Register storage; entry 0 is never written and is masked on read
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read ports are identical, so build them from one template
  logic [4:0] raddr_a [2];
  assign raddr_a[0] = raddr1;
  assign raddr_a[1] = raddr2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [width-1:0] rd_val;

    // Zero in INIT or for r0, same-cycle bypass of a matching write, else storage
    always_comb begin
      rd_val = '0;
      if ((state_q == RUN) && (raddr_a[gi] != 5'd0)) begin
        if (we && (waddr == raddr_a[gi])) begin
          rd_val = wdata;
        end else begin
          rd_val = mem_q[raddr_a[gi]];
        end
      end
    end
  end

  assign rdata1 = g_rd[0].rd_val;
  assign rdata2 = g_rd[1].rd_val;
  assign ready  = ready_q;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file #(.width(32), .depth(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .ready  (ready)
  );

  // Advance past one rising edge; inputs are changed 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rst has just been released: expect reads masked during INIT and ready
  // low after edges 1..30, high right after edge 31
  task automatic run_scrub(input string tag);
    for (int k = 1; k <= 31; k++) begin
      #1;
      checks++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        errors++;
        $display("FAIL %s_init_mask before edge %0d: rdata1=%h rdata2=%h expected 0", tag, k, rdata1, rdata2);
      end
      tick();
      checks++;
      if (ready !== 1'(k == 31)) begin
        errors++;
        $display("FAIL %s_ready after edge %0d: ready=%b expected %b", tag, k, ready, (k == 31));
      end
    end
  endtask

  // Every address on both ports must read zero
  task automatic read_all_zero(input string tag);
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #1;
      checks++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        errors++;
        $display("FAIL %s_zero r%0d/r%0d: rdata1=%h rdata2=%h expected 0", tag, i, 31 - i, rdata1, rdata2);
      end
    end
    $display("%s: read all 32 registers", tag);
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'h0; raddr1 = 5'd5; raddr2 = 5'd31;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (ready !== 1'b0 || rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: ready=%b rdata1=%h rdata2=%h expected 0/0/0", c, ready, rdata1, rdata2);
      end
    end
    rst = 1'b0;
    run_scrub("reset");
    read_all_zero("reset");
  endtask

  task automatic test_basic();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd5;
    #1;
    checks++;
    if (rdata1 !== 32'hDEADBEEF || rdata2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_rw: rdata1=%h rdata2=%h expected deadbeef", rdata1, rdata2);
    end
    $display("basic: wrote r5=deadbeef, read %h %h", rdata1, rdata2);
  endtask

  task automatic test_reg0();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL reg0_bypass: rdata1=%h rdata2=%h expected 0", rdata1, rdata2);
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL reg0_stored: rdata1=%h rdata2=%h expected 0", rdata1, rdata2);
    end
    $display("reg0: write ffffffff to r0, read %h", rdata1);
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd8; wdata = 32'h88;
    tick();
    waddr = 5'd7; wdata = 32'h11;
    tick();
    waddr = 5'd7; wdata = 32'h22; raddr1 = 5'd7; raddr2 = 5'd8;
    #1;
    checks++;
    if (rdata1 !== 32'h22 || rdata2 !== 32'h88) begin
      errors++;
      $display("FAIL bypass_same_cycle: rdata1=%h rdata2=%h expected 22/88", rdata1, rdata2);
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 32'h22 || rdata2 !== 32'h88) begin
      errors++;
      $display("FAIL bypass_stored: rdata1=%h rdata2=%h expected 22/88", rdata1, rdata2);
    end
    $display("bypass: r7 write 22 seen %h, r8=%h", rdata1, rdata2);
  endtask

  task automatic test_init_writes();
    rst = 1'b1; we = 1'b0;
    tick();
    rst = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'hAA; raddr1 = 5'd3; raddr2 = 5'd5;
    run_scrub("init_we");
    we = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL init_we_after: r3=%h r5=%h expected 0/0", rdata1, rdata2);
    end
    $display("init_we: after scrub r3=%h r5=%h", rdata1, rdata2);
  endtask

  task automatic test_reset_mid_scrub_and_run();
    we = 1'b1;
    for (int i = 1; i < 32; i++) begin
      waddr = 5'(i);
      wdata = 32'h1000_0000 + 32'(i) * 32'h0101;
      tick();
    end
    we = 1'b0; raddr1 = 5'd31; raddr2 = 5'd1;
    #1;
    checks++;
    if (rdata1 !== 32'h1000_1F1F || rdata2 !== 32'h1000_0101) begin
      errors++;
      $display("FAIL fill: r31=%h r1=%h expected 10001f1f/10000101", rdata1, rdata2);
    end
    // Reset in RUN, with a write request that must lose to reset
    rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h99;
    tick();
    rst = 1'b0; we = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL run_reset_mask: ready=%b r31=%h r1=%h expected 0/0/0", ready, rdata1, rdata2);
    end
    for (int c = 0; c < 10; c++) tick();
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_scrub_ready: ready=%b expected 0", ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_scrub("mid");
    read_all_zero("mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reg0();
    test_bypass();
    test_init_writes();
    test_reset_mid_scrub_and_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
